lfsr_seq_ctrl: RTL and testbench
================================

# lfsr_seq_ctrl

Sequencing controller for the 8-bit Galois LFSR block. On each request it can reseed the LFSR and clocks it for a programmable number of generate cycles. It then drives the LFSR's serial read-out, reassembles the eight serial bits into a byte and presents that byte on a valid/ready interface. It sits between the LFSR instance and any consumer of random bytes, and it owns the LFSR's `enable`, `out_enable` and reset pins.

## Interface
- `SHIFT_W`, 8: width of `shift_count`; maximum run is 2^SHIFT_W−1 generate cycles.
- `LFSR_W`, 8: LFSR width; also the number of serial bits per read-out.
- `clock` in 1: single clock for the block and the LFSR.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: request; sampled only in IDLE.
- `reseed` in 1: qualifies `start`; reloads the LFSR seed before generating.
- `shift_count` in SHIFT_W: generate cycles; captured when the request is accepted.
- `busy` out 1: high in every state except IDLE.
- `lfsr_rst_n` out 1: to the LFSR `reset` pin; driven directly by a dedicated flop.
- `lfsr_enable` out 1: to the LFSR `enable` pin.
- `lfsr_out_enable` out 1: to the LFSR `out_enable` pin.
- `lfsr_valid` in 1: from the LFSR `Valid` pin.
- `lfsr_out` in 1: from the LFSR `OUT` pin.
- `rnd_data` out LFSR_W: assembled byte.
- `rnd_valid` out 1: `rnd_data` is valid.
- `rnd_ready` in 1: consumer accepts the byte.

## Operation
- States and transitions:
  - IDLE: when `start` is high, go to RESEED if `reseed` is high, else to SHIFT. If `shift_count` is 0, SHIFT is skipped and the next state is READ.
  - RESEED: one cycle, then SHIFT, or READ if the count is 0.
  - SHIFT: lasts `shift_count` cycles, then READ.
  - READ: lasts exactly LFSR_W cycles, then WAIT.
  - WAIT: one cycle, then PRESENT.
  - PRESENT: go to IDLE on the cycle `rnd_valid && rnd_ready`.
- `lfsr_enable` = (state==SHIFT).
- `lfsr_out_enable` = (state==READ).
- Both are Moore decodes of the state register and are never high together.
- `lfsr_rst_n` is low only during the RESEED cycle. It comes from its own flop so the LFSR's asynchronous reset is glitch-free.
- Capture rule: in READ or WAIT, each cycle with `lfsr_valid` high shifts in one bit: `rnd_data <= {lfsr_out, rnd_data[LFSR_W-1:1]}`.
  - The first bit received lands in bit 0, so `rnd_data` equals the LFSR register value at READ entry.
  - `lfsr_valid` is ignored in all other states.
- One down-counter serves both SHIFT (loaded with `shift_count`) and READ (loaded with LFSR_W). It is loaded on state entry and the state exits at terminal count.
- `rnd_valid` is high throughout PRESENT. `rnd_data` is held stable while `rnd_valid` is high and `rnd_ready` is low.
- `start` is ignored outside IDLE, including in PRESENT. A new request is accepted no earlier than the cycle after the transfer.
- Read-out is destructive: the LFSR shifts right with zero fill, so after READ it holds 0. Its feedback escapes the all-zero state, so continuing without a reseed is legal.

## Timing
- Reset values: state IDLE, `busy` 0, `lfsr_rst_n` 0, `lfsr_enable` 0, `lfsr_out_enable` 0, `rnd_valid` 0, `rnd_data` 0.
  - Because `lfsr_rst_n` resets to 0, the LFSR is held at its seed during controller reset.
  - `lfsr_rst_n` rises on the first clock edge after `reset` deasserts.
- Take the accept edge as cycle 0 and N = `shift_count`:
  - SHIFT: cycles 1..N.
  - READ: cycles N+1..N+8.
  - LFSR `Valid`: cycles N+2..N+9.
  - WAIT: cycle N+9.
  - `rnd_valid` first high: cycle N+10.
- With `reseed`, every figure above is one cycle later. With N=0, READ starts at cycle 1 (or 2 with `reseed`).
- `busy` rises the cycle after accept and falls the cycle after the transfer.
- Reset asserted mid-operation: everything returns immediately to reset values, and any partially captured byte is discarded.

## Structure
- Package `lfsr_seq_pkg`: state enum (IDLE, RESEED, SHIFT, READ, WAIT, PRESENT) and the default constants LFSR_W=8 and SHIFT_W=8.
- Sub-module `lfsr_seq_cnt`: loadable down-counter with a terminal-count flag, shared by SHIFT and READ.
- Everything else stays in the top module.

## Test plan
Benches use the real LFSR instance with Seed=8'h5A, and `rnd_ready` is held high unless stated otherwise.
- Reset release followed by `start` with `reseed`=1 and N=0:
  - `lfsr_rst_n` is low for exactly one cycle.
  - `rnd_data`=8'h5A and `rnd_valid` first rises at cycle 11.
- `start` with `reseed`=1 and N=1: `rnd_data`=8'hB4.
- Immediately afterwards, `start` with `reseed`=0 and N=1 (the LFSR now holds 0): `rnd_data`=8'hAB, with `rnd_valid` at cycle 11.
- Hold `rnd_ready` low for 5 cycles in PRESENT:
  - `rnd_valid` and `rnd_data` stay stable.
  - `start` pulses during this window are ignored.
  - `busy` falls one cycle after `rnd_ready` rises.
- N=255: `lfsr_enable` is high for exactly 255 consecutive cycles, with `lfsr_out_enable` low throughout.
- Assert `reset` during READ at cycle 4 of a read-out: all outputs return to reset values immediately. The next request with N=0 yields 8'h5A.

Source files
------------

// File: rtl/lfsr_seq_pkg.sv
// Shared definitions for the LFSR sequencing controller.
//   state_e            : controller FSM states
//   LFSR_W_DEFAULT     : LFSR width, also serial bits per read-out
//   SHIFT_W_DEFAULT    : width of the generate-cycle count
package lfsr_seq_pkg;

  localparam int LFSR_W_DEFAULT  = 8;
  localparam int SHIFT_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESEED  = 3'd1,
    SHIFT   = 3'd2,
    READ    = 3'd3,
    WAIT    = 3'd4,
    PRESENT = 3'd5
  } state_e;

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Byte output channel of the LFSR sequencing controller.
//   rnd_data  : assembled random byte
//   rnd_valid : rnd_data is valid
//   rnd_ready : consumer accepts the byte
//
// Handshake: a transfer happens on every rising clock edge where
// rnd_valid && rnd_ready. Once rnd_valid is high, the producer keeps
// rnd_valid and rnd_data unchanged until that transfer; rnd_valid never
// depends combinationally on rnd_ready.
interface lfsr_seq_ctrl_if
  import lfsr_seq_pkg::*;
#(
  parameter int W = LFSR_W_DEFAULT
);

  logic [W-1:0] rnd_data;
  logic         rnd_valid;
  logic         rnd_ready;

  modport master (output rnd_data, output rnd_valid, input rnd_ready);
  modport slave  (input rnd_data, input rnd_valid, output rnd_ready);

endinterface

// File: rtl/lfsr_seq_cnt.sv
// Loadable down-counter shared by the SHIFT and READ phases.
//   clock, reset : clock and asynchronous active-low reset
//   load         : load load_val (wins over dec)
//   load_val     : value loaded on state entry
//   dec          : count down by one (saturates at zero)
//   tc           : terminal count, the current cycle is the last one (count == 1)
//   zero         : count is zero
module lfsr_seq_cnt
  import lfsr_seq_pkg::*;
#(
  parameter int W = SHIFT_W_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc   = (cnt_q == W'(1));
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencing controller for an 8-bit Galois LFSR: optionally reseeds it,
// clocks it for shift_count generate cycles, drives its serial read-out and
// reassembles the bits into a byte offered on a valid/ready channel.
//   clock, reset     : clock and asynchronous active-low reset
//   start, reseed    : request (sampled in IDLE only) and its reseed qualifier
//   shift_count      : generate cycles, captured on accept
//   busy             : high in every state except IDLE
//   lfsr_rst_n       : LFSR reset pin, low only during RESEED (flopped)
//   lfsr_enable      : LFSR enable pin, high in SHIFT
//   lfsr_out_enable  : LFSR out_enable pin, high in READ
//   lfsr_valid       : LFSR Valid pin
//   lfsr_out         : LFSR OUT pin
//   rnd_if           : byte output channel (master side)
//   dbg_state        : current FSM state
module lfsr_seq_ctrl
  import lfsr_seq_pkg::*;
#(
  parameter int SHIFT_W = SHIFT_W_DEFAULT,
  parameter int LFSR_W  = LFSR_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               reseed,
  input  logic [SHIFT_W-1:0] shift_count,
  output logic               busy,
  output logic               lfsr_rst_n,
  output logic               lfsr_enable,
  output logic               lfsr_out_enable,
  input  logic               lfsr_valid,
  input  logic               lfsr_out,
  lfsr_seq_ctrl_if.master    rnd_if,
  output state_e             dbg_state
);

  // The counter must hold both the largest shift count and the read length.
  localparam int CNT_W = (SHIFT_W > $clog2(LFSR_W + 1)) ? SHIFT_W : $clog2(LFSR_W + 1);
  localparam logic [CNT_W-1:0] READ_LEN = CNT_W'(LFSR_W);

  state_e            state_q, state_d;
  logic              lfsr_rst_n_q, lfsr_rst_n_d;
  logic [LFSR_W-1:0] rnd_data_q, rnd_data_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_dec;
  logic              cnt_tc;
  logic              cnt_zero;

  lfsr_seq_cnt #(.W(CNT_W)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .tc       (cnt_tc),
    .zero     (cnt_zero)
  );

  // Next state and counter control. The counter is loaded with shift_count
  // on accept; RESEED leaves it untouched so SHIFT starts from the captured
  // value. Entering READ always reloads it with the read length.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(shift_count);
          if (reseed) begin
            state_d = RESEED;
          end else if (shift_count == '0) begin
            state_d = READ;
            cnt_val = READ_LEN;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      RESEED: begin
        if (cnt_zero) begin
          state_d  = READ;
          cnt_load = 1'b1;
          cnt_val  = READ_LEN;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        cnt_dec = 1'b1;
        if (cnt_tc) begin
          state_d  = READ;
          cnt_load = 1'b1;
          cnt_val  = READ_LEN;
        end
      end
      READ: begin
        cnt_dec = 1'b1;
        if (cnt_tc) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d = PRESENT;
      end
      PRESENT: begin
        if (rnd_if.rnd_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The LFSR Valid pin lags out_enable by one cycle, so the last serial bit
  // arrives during WAIT; capture therefore covers READ and WAIT. The first
  // bit lands in bit 0 after all shifts, reproducing the LFSR register value.
  always_comb begin
    rnd_data_d = rnd_data_q;
    if (((state_q == READ) || (state_q == WAIT)) && lfsr_valid) begin
      rnd_data_d = {lfsr_out, rnd_data_q[LFSR_W-1:1]};
    end
  end

  // Decoding from state_d makes the flop output low exactly while the state
  // register holds RESEED, without any combinational path to the LFSR reset.
  always_comb begin
    lfsr_rst_n_d = (state_d != RESEED);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      lfsr_rst_n_q <= 1'b0;
      rnd_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_rst_n_q <= lfsr_rst_n_d;
      rnd_data_q   <= rnd_data_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign lfsr_rst_n       = lfsr_rst_n_q;
  assign lfsr_enable      = (state_q == SHIFT);
  assign lfsr_out_enable  = (state_q == READ);
  assign rnd_if.rnd_valid = (state_q == PRESENT);
  assign rnd_if.rnd_data  = rnd_data_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl. Contains a behavioural stand-in for the 8-bit
// Galois LFSR (seed 8'h5A, destructive right-shift read-out with one cycle of
// Valid latency) and a reference model that tracks the LFSR contents per
// request to predict every byte and its arrival cycle.
module tb_lfsr_seq_ctrl;
  import lfsr_seq_pkg::*;

  localparam logic [7:0] SEED = 8'h5A;
  localparam logic [7:0] TAPS = 8'hAB;
  localparam int         LIMIT = 400;

  logic       clock;
  logic       reset;
  logic       start;
  logic       reseed_i;
  logic [7:0] shift_count;
  logic       busy;
  logic       lfsr_rst_n;
  logic       lfsr_enable;
  logic       lfsr_out_enable;
  logic       lfsr_valid;
  logic       lfsr_out;
  state_e     dbg_state;

  lfsr_seq_ctrl_if #(.W(8)) rnd_if ();

  lfsr_seq_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .reseed          (reseed_i),
    .shift_count     (shift_count),
    .busy            (busy),
    .lfsr_rst_n      (lfsr_rst_n),
    .lfsr_enable     (lfsr_enable),
    .lfsr_out_enable (lfsr_out_enable),
    .lfsr_valid      (lfsr_valid),
    .lfsr_out        (lfsr_out),
    .rnd_if          (rnd_if.master),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- LFSR stand-in ----------------
  // One generate step: shift left, XOR taps when the MSB falls out; the
  // all-zero state also takes the taps so the register escapes zero.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic [7:0] n;
    n = {s[6:0], 1'b0};
    if (s[7] || (s == 8'h00)) n = n ^ TAPS;
    return n;
  endfunction

  logic [7:0] m_reg;
  logic       m_valid;
  logic       m_out;

  always @(posedge clock or negedge lfsr_rst_n) begin
    if (!lfsr_rst_n) begin
      m_reg   <= SEED;
      m_valid <= 1'b0;
      m_out   <= 1'b0;
    end else begin
      m_valid <= lfsr_out_enable;
      if (lfsr_out_enable) begin
        m_out <= m_reg[0];
        m_reg <= m_reg >> 1;
      end else if (lfsr_enable) begin
        m_reg <= lfsr_step(m_reg);
      end
    end
  end

  assign lfsr_valid = m_valid;
  assign lfsr_out   = m_out;

  // ---------------- scoreboard ----------------
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mdl_state;   // reference view of the LFSR register contents

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: a request optionally reloads the seed, advances the register
  // by n generate steps, and the byte read out is that value; read-out then
  // leaves the register empty.
  function automatic logic [7:0] model_request(input logic rs, input int n);
    logic [7:0] s;
    s = rs ? SEED : mdl_state;
    for (int i = 0; i < n; i++) s = lfsr_step(s);
    mdl_state = 8'h00;
    return s;
  endfunction

  // ---------------- driver ----------------
  // Accept edge is cycle 0; samples are taken at the falling edge inside
  // each cycle. d = number of PRESENT cycles with rnd_ready held low.
  task automatic run_txn(input logic rs, input int n, input int d, input int exp_lat);
    int         cyc, lat, en_cnt, oe_cnt, rl_cnt, overlap, en_first, oe_first, hold_bad;
    logic [7:0] exp_data;
    exp_data = exp_q.pop_front();
    @(negedge clock);
    start       = 1'b1;
    reseed_i    = rs;
    shift_count = 8'(n);
    rnd_if.rnd_ready = (d == 0);
    @(negedge clock);
    start = 1'b0;
    check("busy_rise", int'(busy), 1);
    cyc = 1; lat = -1; en_cnt = 0; oe_cnt = 0; rl_cnt = 0; overlap = 0;
    en_first = -1; oe_first = -1;
    while (cyc < LIMIT) begin
      if (rnd_if.rnd_valid) begin
        lat = cyc;
        break;
      end
      if (lfsr_enable) begin
        en_cnt++;
        if (en_first < 0) en_first = cyc;
      end
      if (lfsr_out_enable) begin
        oe_cnt++;
        if (oe_first < 0) oe_first = cyc;
      end
      if (!lfsr_rst_n) rl_cnt++;
      if (lfsr_enable && lfsr_out_enable) overlap++;
      @(negedge clock);
      cyc++;
    end
    check("valid_latency", lat, exp_lat);
    check("rnd_data", int'(rnd_if.rnd_data), int'(exp_data));
    check("enable_cycles", en_cnt, n);
    check("out_enable_cycles", oe_cnt, 8);
    check("rst_low_cycles", rl_cnt, int'(rs));
    check("en_oe_overlap", overlap, 0);
    check("enable_first", en_first, (n > 0) ? 1 + int'(rs) : -1);
    check("out_enable_first", oe_first, n + 1 + int'(rs));
    if (lat < 0) begin
      rnd_if.rnd_ready = 1'b1;
      return;
    end
    hold_bad = 0;
    for (int i = 0; i < d; i++) begin
      if (!rnd_if.rnd_valid || (rnd_if.rnd_data != exp_data) || !busy) hold_bad++;
      start       = 1'($urandom_range(0, 1));
      reseed_i    = 1'($urandom_range(0, 1));
      shift_count = 8'($urandom_range(0, 3));
      @(negedge clock);
    end
    check("hold_stable", hold_bad, 0);
    check("hold_valid", int'(rnd_if.rnd_valid), 1);
    check("hold_data", int'(rnd_if.rnd_data), int'(exp_data));
    start = 1'b0;
    rnd_if.rnd_ready = 1'b1;
    @(negedge clock);
    check("busy_fall", int'(busy), 0);
    check("valid_fall", int'(rnd_if.rnd_valid), 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       rs;
    int         n;
    int         d;
    logic       known;     // exp_data is a hand-derived constant
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] e;
    vecs[0] = '{rs: 1'b1, n: 0,   d: 0, known: 1'b1, exp_data: 8'h5A, exp_lat: 11};
    vecs[1] = '{rs: 1'b1, n: 1,   d: 0, known: 1'b1, exp_data: 8'hB4, exp_lat: 12};
    vecs[2] = '{rs: 1'b0, n: 1,   d: 0, known: 1'b1, exp_data: 8'hAB, exp_lat: 11};
    vecs[3] = '{rs: 1'b1, n: 3,   d: 5, known: 1'b1, exp_data: 8'h2D, exp_lat: 14};
    vecs[4] = '{rs: 1'b0, n: 255, d: 0, known: 1'b0, exp_data: 8'h00, exp_lat: 265};

    // reset state
    reset = 1'b0; start = 1'b0; reseed_i = 1'b0; shift_count = '0;
    rnd_if.rnd_ready = 1'b1;
    mdl_state = SEED;
    repeat (3) @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_lfsr_rst_n", int'(lfsr_rst_n), 0);
    check("rst_enable", int'(lfsr_enable), 0);
    check("rst_out_enable", int'(lfsr_out_enable), 0);
    check("rst_valid", int'(rnd_if.rnd_valid), 0);
    check("rst_data", int'(rnd_if.rnd_data), 0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    reset = 1'b1;
    @(negedge clock);
    check("lfsr_rst_n_release", int'(lfsr_rst_n), 1);

    foreach (vecs[i]) begin
      e = model_request(vecs[i].rs, vecs[i].n);
      exp_q.push_back(vecs[i].known ? vecs[i].exp_data : e);
      run_txn(vecs[i].rs, vecs[i].n, vecs[i].d, vecs[i].exp_lat);
    end

    // randomized requests against the reference model
    for (int k = 0; k < 12; k++) begin
      logic rs;
      int   n, d;
      rs = 1'($urandom_range(0, 1));
      n  = $urandom_range(0, 20);
      d  = $urandom_range(0, 3);
      exp_q.push_back(model_request(rs, n));
      run_txn(rs, n, d, n + 10 + int'(rs));
    end

    // reset during the fourth read-out cycle (reseed, N=2 => READ at 4..11)
    @(negedge clock);
    start = 1'b1; reseed_i = 1'b1; shift_count = 8'd2;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    check("mid_read_out_enable", int'(lfsr_out_enable), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_lfsr_rst_n", int'(lfsr_rst_n), 0);
    check("mid_rst_enable", int'(lfsr_enable), 0);
    check("mid_rst_out_enable", int'(lfsr_out_enable), 0);
    check("mid_rst_valid", int'(rnd_if.rnd_valid), 0);
    check("mid_rst_data", int'(rnd_if.rnd_data), 0);
    mdl_state = SEED;   // LFSR held at its seed while the controller is in reset
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_lfsr_rst_n", int'(lfsr_rst_n), 1);
    exp_q.push_back(8'h5A);
    void'(model_request(1'b0, 0));
    run_txn(1'b0, 0, 0, 10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
